// File: rtl/pll_sup_pkg.sv
// Shared types and default tuning for the PLL lock supervisor.
// State encodings are exposed on state_o, so they are fixed here.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'b00,
      STABILIZE = 2'b01,
      RUN       = 2'b10,
      LOST      = 2'b11
   } pll_sup_state_t;

   localparam int SYNC_STAGES_DEF    = 2;
   localparam int STABLE_CYCLES_DEF  = 4096;
   localparam int LOSS_FILTER_DEF    = 4;
   localparam int RST_MIN_CYCLES_DEF = 256;
   localparam int LOSS_CNT_W_DEF     = 8;

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop synchroniser for asynchronous single-bit inputs, cleared to 0 by rst.
// Output is the input delayed by STAGES clk edges.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous PLL lock and drives a clean system reset with loss tracking.
// sys_rst_o/sys_ready_o are one register stage behind the FSM state.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
   parameter int LOSS_FILTER    = LOSS_FILTER_DEF,
   parameter int RST_MIN_CYCLES = RST_MIN_CYCLES_DEF,
   parameter int LOSS_CNT_W     = LOSS_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked_i,
   input  logic                  clear_flag_i,
   output logic                  sys_rst_o,
   output logic                  sys_ready_o,
   output logic                  lost_flag_o,
   output logic [LOSS_CNT_W-1:0] loss_count_o,
   output logic [1:0]            state_o
);

   localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
   localparam int LOW_W  = $clog2(LOSS_FILTER) + 1;
   localparam int HOLD_W = $clog2(RST_MIN_CYCLES) + 1;

   pll_sup_state_t    state, state_nxt;
   logic [STAB_W-1:0] stab_cnt, stab_cnt_nxt;
   logic [LOW_W-1:0]  low_cnt, low_cnt_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              lock_s;
   logic              loss_evt;

   sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked_i),
      .q   (lock_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_LOCK;
         stab_cnt <= '0;
         low_cnt  <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         stab_cnt <= stab_cnt_nxt;
         low_cnt  <= low_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      stab_cnt_nxt = '0;
      low_cnt_nxt  = '0;
      hold_cnt_nxt = '0;
      loss_evt     = 1'b0;
      unique case (state)
         WAIT_LOCK: begin
            if (lock_s) begin
               // A single required sample means the first high edge already qualifies.
               if (STABLE_CYCLES == 1) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt    = STABILIZE;
                  stab_cnt_nxt = STAB_W'(1);
               end
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
            end else if (stab_cnt == STAB_W'(STABLE_CYCLES - 1)) begin
               state_nxt = RUN;
            end else begin
               stab_cnt_nxt = stab_cnt + STAB_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               if (low_cnt == LOW_W'(LOSS_FILTER - 1)) begin
                  state_nxt = LOST;
                  loss_evt  = 1'b1;
               end else begin
                  low_cnt_nxt = low_cnt + LOW_W'(1);
               end
            end
         end
         LOST: begin
            if (hold_cnt == HOLD_W'(RST_MIN_CYCLES - 1)) begin
               state_nxt = WAIT_LOCK;
            end else begin
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // A loss on the same edge as a clear request leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         sys_rst_o    <= 1'b1;
         sys_ready_o  <= 1'b0;
         lost_flag_o  <= 1'b0;
         loss_count_o <= '0;
      end else begin
         sys_rst_o   <= (state != RUN);
         sys_ready_o <= (state == RUN);
         if (loss_evt)          lost_flag_o <= 1'b1;
         else if (clear_flag_i) lost_flag_o <= 1'b0;
         if (loss_evt && (loss_count_o != '1))
            loss_count_o <= loss_count_o + LOSS_CNT_W'(1);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomised lock patterns checked every edge against a run-length model of the supervisor.
module tb_pll_lock_supervisor;

   localparam int SYNC   = 2;
   localparam int STABLE = 16;
   localparam int LOSSF  = 4;
   localparam int RMIN   = 8;
   localparam int CW     = 2;
   localparam int CMAX   = (1 << CW) - 1;

   localparam int P_ARM  = 0;
   localparam int P_RUN  = 1;
   localparam int P_LOST = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pll = 1'b0;
   logic          clr = 1'b0;
   logic          sys_rst, sys_ready, lost_flag;
   logic [CW-1:0] loss_count;
   logic [1:0]    state;

   int n_pass  = 0;
   int n_total = 0;

   // Model: lock history, phase, and run lengths of consecutive synced samples.
   bit sh0, sh1;
   int phase, hi_run, lo_run, hold_edges;
   bit e_rst, e_rdy, e_flag;
   int e_cnt;

   always #20 clk = ~clk;

   pll_lock_supervisor #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .LOSS_FILTER   (LOSSF),
      .RST_MIN_CYCLES(RMIN),
      .LOSS_CNT_W    (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked_i (pll),
      .clear_flag_i (clr),
      .sys_rst_o    (sys_rst),
      .sys_ready_o  (sys_ready),
      .lost_flag_o  (lost_flag),
      .loss_count_o (loss_count),
      .state_o      (state)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_edge(input bit p, input bit c, input bit r);
      bit ls, was_run, evt;
      if (r) begin
         phase = P_ARM; hi_run = 0; lo_run = 0; hold_edges = 0;
         sh0 = 0; sh1 = 0;
         e_rst = 1; e_rdy = 0; e_flag = 0; e_cnt = 0;
      end else begin
         ls      = sh1;
         sh1     = sh0;
         sh0     = p;
         was_run = (phase == P_RUN);
         evt     = 0;
         case (phase)
            P_ARM: begin
               if (ls) begin
                  hi_run++;
                  if (hi_run >= STABLE) begin phase = P_RUN; lo_run = 0; end
               end else hi_run = 0;
            end
            P_RUN: begin
               if (!ls) begin
                  lo_run++;
                  if (lo_run >= LOSSF) begin phase = P_LOST; hold_edges = 0; evt = 1; end
               end else lo_run = 0;
            end
            default: begin
               hold_edges++;
               if (hold_edges >= RMIN) begin phase = P_ARM; hi_run = 0; end
            end
         endcase
         e_rst = !was_run;
         e_rdy = was_run;
         if (evt) begin
            e_flag = 1;
            if (e_cnt < CMAX) e_cnt++;
         end else if (c) e_flag = 0;
      end
   endtask

   function automatic logic [7:0] exp_state();
      if (phase == P_RUN)  return 8'd2;
      if (phase == P_LOST) return 8'd3;
      return (hi_run > 0) ? 8'd1 : 8'd0;
   endfunction

   task automatic step(input bit p, input bit c, input bit r);
      pll = p; clr = c; rst = r;
      @(posedge clk);
      model_edge(p, c, r);
      #1;
      chk("sys_rst",   8'(sys_rst),    8'(e_rst));
      chk("sys_ready", 8'(sys_ready),  8'(e_rdy));
      chk("lost_flag", 8'(lost_flag),  8'(e_flag));
      chk("loss_cnt",  8'(loss_count), 8'(e_cnt));
      chk("state",     8'(state),      exp_state());
   endtask

   task automatic lose_lock(input bit clr_on_loss);
      for (int j = 0; j < 12; j++) step(1'b0, clr_on_loss && (j == 5), 1'b0);
   endtask

   initial begin
      bit lvl;
      int len;

      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("reset_rst",   8'(sys_rst),    8'd1);
      chk("reset_ready", 8'(sys_ready),  8'd0);
      chk("reset_flag",  8'(lost_flag),  8'd0);
      chk("reset_cnt",   8'(loss_count), 8'd0);

      // Lock held high from the first edge after reset.
      for (int i = 0; i <= 18; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 17) chk("t1_rst_edge17", 8'(sys_rst), 8'd1);
         if (i == 18) begin
            chk("t1_rst_edge18",   8'(sys_rst),   8'd0);
            chk("t1_ready_edge18", 8'(sys_ready), 8'd1);
         end
      end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);

      // Short dip in RUN is filtered.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      chk("t3_rst",  8'(sys_rst),    8'd0);
      chk("t3_flag", 8'(lost_flag),  8'd0);
      chk("t3_cnt",  8'(loss_count), 8'd0);

      // First real loss.
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 1'b0, 1'b0);
         if (j == 5) begin
            chk("t4_flag", 8'(lost_flag),  8'd1);
            chk("t4_cnt",  8'(loss_count), 8'd1);
         end
         if (j == 6) chk("t4_rst", 8'(sys_rst), 8'd1);
      end
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);

      // Four more losses, clear pulse coinciding with each loss edge.
      for (int k = 0; k < 4; k++) begin
         lose_lock(1'b1);
         chk("t5_flag_set_wins", 8'(lost_flag), 8'd1);
         for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
      end
      chk("t5_cnt_sat", 8'(loss_count), 8'(CMAX));
      step(1'b1, 1'b1, 1'b0);
      chk("t5_lone_clear", 8'(lost_flag), 8'd0);
      chk("t5_cnt_kept",   8'(loss_count), 8'(CMAX));

      // Reset mid-RUN.
      step(1'b1, 1'b0, 1'b1);
      chk("t6_rst",   8'(sys_rst),    8'd1);
      chk("t6_cnt",   8'(loss_count), 8'd0);
      chk("t6_flag",  8'(lost_flag),  8'd0);
      chk("t6_state", 8'(state),      8'd0);
      for (int i = 0; i <= 18; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 17) chk("t6_rst_held", 8'(sys_rst), 8'd1);
         if (i == 18) chk("t6_release",  8'(sys_rst), 8'd0);
      end

      // A one-cycle glitch during stabilisation restarts the timer.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 19; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (k == 18) chk("t2_rst_held", 8'(sys_rst), 8'd1);
         if (k == 19) chk("t2_release",  8'(sys_rst), 8'd0);
      end

      // Toggling lock from WAIT_LOCK never qualifies.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) step(1'(i % 2), 1'b0, 1'b0);
      chk("toggle_no_run", 8'(sys_ready), 8'd0);

      // Randomised lock run lengths, clears and occasional resets.
      lvl = 1'b1;
      for (int s = 0; s < 60; s++) begin
         len = (lvl) ? $urandom_range(1, 30) : $urandom_range(1, 8);
         for (int i = 0; i < len; i++)
            step(lvl, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
         lvl = ~lvl;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
